ubc_pwm_stage: RTL and testbench

//  Downstream consumer of the universal binary counter: turns its count value Q and max/min

---
 rtl/ubc_pkg.sv | 17 +
 rtl/ubc_duty_shadow.sv | 60 ++++++
 rtl/ubc_pwm_stage.sv | 114 +++++++++++
 tb/tb_ubc_pwm_stage.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ubc_pkg.sv
// Shared types and helpers for the universal-binary-counter PWM stage.
package ubc_pkg;

  typedef enum logic [1:0] {
    PWM_IDLE = 2'd0,
    PWM_SYNC = 2'd1,
    PWM_RUN  = 2'd2
  } pwm_state_t;

  // Limit a requested duty to the full-period value 2^n.
  function automatic logic [31:0] clamp_duty(input logic [31:0] duty, input int n);
    logic [31:0] lim;
    lim = 32'd1 << n;
    return (duty > lim) ? lim : duty;
  endfunction

endpackage

// File: rtl/ubc_duty_shadow.sv
// Double-buffered duty/polarity: writes land in pend, the boundary commit moves
// pend into the active compare value together with the sampled polarity.
module ubc_duty_shadow #(
  parameter int   N        = 4,
  parameter logic POL_INIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [N:0] duty_in,
  input  logic       duty_wr,
  input  logic       pol,
  input  logic       commit,
  output logic [N:0] active,
  output logic       pol_act,
  output logic       duty_pend
);
  import ubc_pkg::*;

  localparam int DW = N + 1;

  logic [DW-1:0] pend_r;
  logic [DW-1:0] active_r;
  logic          pol_act_r;
  logic          duty_pend_r;
  logic [DW-1:0] clamped_s;

  // Clamp the incoming request to 2^N before it is buffered.
  always_comb begin
    clamped_s = DW'(clamp_duty(32'(duty_in), N));
  end

  // A write coinciding with the commit still commits the old pend and leaves
  // the new value pending for the following boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r      <= '0;
      active_r    <= '0;
      pol_act_r   <= POL_INIT;
      duty_pend_r <= 1'b0;
    end else begin
      if (duty_wr) begin
        pend_r <= clamped_s;
      end
      if (commit) begin
        active_r  <= pend_r;
        pol_act_r <= pol;
      end
      if (duty_wr) begin
        duty_pend_r <= 1'b1;
      end else if (commit) begin
        duty_pend_r <= 1'b0;
      end
    end
  end

  assign active    = active_r;
  assign pol_act   = pol_act_r;
  assign duty_pend = duty_pend_r;

endmodule

// File: rtl/ubc_pwm_stage.sv
// PWM stage driven by the binary counter: sync-to-boundary FSM, registered
// compare output, period tick and saturating completed-period counter.
module ubc_pwm_stage #(
  parameter int   N        = 4,
  parameter int   PCNT_W   = 8,
  parameter logic POL_INIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N-1:0]      q,
  input  logic              max,
  input  logic              min,
  input  logic              up,
  input  logic [N:0]        duty_in,
  input  logic              duty_wr,
  input  logic              pol,
  output logic              pwm_out,
  output logic              period_tick,
  output logic              duty_pend,
  output logic              running,
  output logic [PCNT_W-1:0] period_cnt
);
  import ubc_pkg::*;

  pwm_state_t        state_r;
  logic              pwm_r;
  logic              tick_r;
  logic              running_r;
  logic [PCNT_W-1:0] pcnt_r;
  logic              boundary_s;
  logic              commit_s;
  logic              compare_s;
  logic [N:0]        active_s;
  logic              pol_act_s;

  ubc_duty_shadow #(.N(N), .POL_INIT(POL_INIT)) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .duty_in   (duty_in),
    .duty_wr   (duty_wr),
    .pol       (pol),
    .commit    (commit_s),
    .active    (active_s),
    .pol_act   (pol_act_s),
    .duty_pend (duty_pend)
  );

  // Period boundary depends on count direction; q is zero-extended so that
  // active = 2^N compares true for every count.
  always_comb begin
    boundary_s = (up & max) | (~up & min);
    commit_s   = boundary_s & (state_r != PWM_IDLE);
    compare_s  = ({1'b0, q} < active_s) ? pol_act_s : ~pol_act_s;
  end

  // Sequencer with registered pwm/tick/running/period outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= PWM_IDLE;
      pwm_r     <= ~POL_INIT;
      tick_r    <= 1'b0;
      running_r <= 1'b0;
      pcnt_r    <= '0;
    end else begin
      case (state_r)
        PWM_IDLE: begin
          pwm_r  <= ~pol_act_s;
          tick_r <= 1'b0;
          if (en) begin
            state_r <= PWM_SYNC;
          end
        end
        PWM_SYNC: begin
          pwm_r  <= ~pol_act_s;
          tick_r <= 1'b0;
          if (!en) begin
            state_r <= PWM_IDLE;
          end else if (boundary_s) begin
            state_r   <= PWM_RUN;
            running_r <= 1'b1;
            pcnt_r    <= '0;
          end
        end
        PWM_RUN: begin
          if (!en) begin
            state_r   <= PWM_IDLE;
            running_r <= 1'b0;
            pwm_r     <= ~pol_act_s;
            tick_r    <= 1'b0;
          end else begin
            pwm_r  <= compare_s;
            tick_r <= boundary_s;
            if (boundary_s && (pcnt_r != {PCNT_W{1'b1}})) begin
              pcnt_r <= pcnt_r + PCNT_W'(1);
            end
          end
        end
        default: begin
          state_r   <= PWM_IDLE;
          pwm_r     <= ~pol_act_s;
          tick_r    <= 1'b0;
          running_r <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_out     = pwm_r;
  assign period_tick = tick_r;
  assign running     = running_r;
  assign period_cnt  = pcnt_r;

endmodule

// File: tb/tb_ubc_pwm_stage.sv
// Directed + randomized bench for ubc_pwm_stage against a cycle-level
// behavioural model of the PWM rules, with a free-running 4-bit counter.
module tb_ubc_pwm_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] q = 4'd0;
  logic       max, min;
  logic       up = 1'b1;
  logic [4:0] duty_in = 5'd0;
  logic       duty_wr = 1'b0;
  logic       pol = 1'b1;
  logic       pwm_out, period_tick, duty_pend, running;
  logic [7:0] period_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model state
  int m_pend, m_act, m_cnt;
  bit m_pol, m_dpend, m_waiting, m_run, m_pwm, m_tick;

  assign max = (q == 4'd15);
  assign min = (q == 4'd0);

  always #5 clk = ~clk;

  ubc_pwm_stage #(.N(4), .PCNT_W(8), .POL_INIT(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .q(q), .max(max), .min(min), .up(up),
    .duty_in(duty_in), .duty_wr(duty_wr), .pol(pol),
    .pwm_out(pwm_out), .period_tick(period_tick), .duty_pend(duty_pend),
    .running(running), .period_cnt(period_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_act = 0; m_cnt = 0;
    m_pol = 1'b1; m_dpend = 1'b0; m_waiting = 1'b0; m_run = 1'b0;
    m_pwm = 1'b0; m_tick = 1'b0;
  endtask

  // Apply one clock of the PWM rules to the model using the current inputs.
  task automatic model_edge();
    bit bnd;
    int act0;
    bit pol0;
    bnd  = up ? (q == 4'd15) : (q == 4'd0);
    act0 = m_act;
    pol0 = m_pol;
    if (m_run && en) begin
      m_pwm  = (int'(q) < act0) ? pol0 : !pol0;
      m_tick = bnd;
      if (bnd && m_cnt < 255) m_cnt++;
    end else begin
      m_pwm  = !pol0;
      m_tick = 1'b0;
    end
    if (bnd && (m_waiting || m_run)) begin
      m_act = m_pend; m_pol = pol; m_dpend = 1'b0;
    end
    if (duty_wr) begin
      m_pend  = (int'(duty_in) > 16) ? 16 : int'(duty_in);
      m_dpend = 1'b1;
    end
    if (m_run) begin
      if (!en) m_run = 1'b0;
    end else if (m_waiting) begin
      if (!en) m_waiting = 1'b0;
      else if (bnd) begin m_waiting = 1'b0; m_run = 1'b1; m_cnt = 0; end
    end else if (en) begin
      m_waiting = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("pwm_out", pwm_out, m_pwm);
    chk("period_tick", period_tick, m_tick);
    chk("duty_pend", duty_pend, m_dpend);
    chk("running", running, m_run);
    chk("period_cnt", period_cnt, m_cnt);
  endtask

  // One clock: model, edge, check #1 later, then advance the counter.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    q = up ? q + 4'd1 : q - 4'd1;
    duty_wr = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write_duty(input logic [4:0] d);
    duty_in = d;
    duty_wr = 1'b1;
    step();
  endtask

  task automatic run_to(input logic [3:0] target);
    for (int i = 0; i < 16 && q != target; i++) step();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pwm"}, pwm_out, 1'b0);
    chk({tag, "_tick"}, period_tick, 1'b0);
    chk({tag, "_dpend"}, duty_pend, 1'b0);
    chk({tag, "_running"}, running, 1'b0);
    chk({tag, "_pcnt"}, period_cnt, 8'd0);
  endtask

  task automatic rst_pulse();
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check_reset_vals("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: duty 6, sync to the first wrap
    en = 1'b1;
    write_duty(5'd6);
    steps(40);
    chk("t1_running", running, 1'b1);

    // 2: duty 0 then clamp 20 -> 16
    run_to(4'd3);
    write_duty(5'd0);
    steps(34);
    write_duty(5'd20);
    steps(34);
    chk("t2_pwm_full", pwm_out, 1'b1);

    // 3: mid-period rewrite
    write_duty(5'd6);
    steps(20);
    run_to(4'd8);
    write_duty(5'd3);
    chk("t3_pend", duty_pend, 1'b1);
    steps(36);

    // 4: write on the exact boundary cycle
    write_duty(5'd12);
    run_to(4'd15);
    write_duty(5'd9);
    chk("t4_pend_kept", duty_pend, 1'b1);
    steps(36);

    // 5: count down, duty 10, then polarity flip at commit
    up = 1'b0;
    write_duty(5'd10);
    steps(36);
    pol = 1'b0;
    steps(36);
    pol = 1'b1;
    up = 1'b1;
    steps(20);

    // 6: reset mid-RUN, resync, then saturate the period counter
    rst_pulse();
    steps(40);
    write_duty(5'd7);
    steps(300 * 16);
    chk("t6_pcnt_sat", period_cnt, 8'd255);

    // randomized phase
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 29) == 0) en = ~en;
      if ($urandom_range(0, 199) == 0) up = ~up;
      if ($urandom_range(0, 9) == 0) pol = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        duty_in = 5'($urandom_range(0, 31));
        duty_wr = 1'b1;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
